// File: rtl/sips_core.sv
// sips_core: small multi-cycle processor with 16-bit instructions, 8 registers,
// request/acknowledge instruction and data memory ports, and registered I/O ports.
module sips_core #(
  parameter int DW   = 8,
  parameter int PCW  = 8,
  parameter int NIN  = 2,
  parameter int NOUT = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PCW-1:0]     imem_addr,
  input  logic               imem_ack,
  input  logic [15:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DW-1:0]      dmem_addr,
  output logic [DW-1:0]      dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DW-1:0]      dmem_rdata,
  input  logic [NIN*DW-1:0]  in_port,
  output logic [NOUT*DW-1:0] out_port,
  output logic               halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [DW-1:0] LP_DW = DW'(DW);

  state_t              r_state;
  state_t              w_nextState;
  logic [15:0]         r_ir;
  logic [PCW-1:0]      r_pc;
  logic [DW-1:0]       r_regs [8];
  logic [3:0]          r_flags;
  logic [NOUT*DW-1:0]  r_outPort;
  logic                r_dmemWe;
  logic [DW-1:0]       r_dmemAddr;
  logic [DW-1:0]       r_dmemWdata;

  logic [4:0]          w_op;
  logic [2:0]          w_rs1;
  logic [3:0]          w_imm;
  logic [2:0]          w_rd;
  logic                w_isel;
  logic [DW-1:0]       w_src1;
  logic [DW-1:0]       w_src2;
  logic [DW-1:0]       w_shamt;
  logic [PCW-1:0]      w_pcPlus1;
  logic [DW:0]         w_sum;
  logic [DW:0]         w_diff;
  logic [DW-1:0]       w_aluRes;
  logic                w_aluV;
  logic                w_aluC;
  logic                w_cond;
  logic                w_taken;
  logic [DW-1:0]       w_inVal;

  logic                w_regWe;
  logic [DW-1:0]       w_regWdata;
  logic                w_flagWe;
  logic                w_pcWe;
  logic [PCW-1:0]      w_pcNext;
  logic                w_outWe;
  logic                w_memStart;

  assign w_op      = r_ir[15:11];
  assign w_rs1     = r_ir[10:8];
  assign w_imm     = r_ir[7:4];
  assign w_rd      = r_ir[3:1];
  assign w_isel    = r_ir[0];
  assign w_src1    = r_regs[w_rs1];
  assign w_src2    = w_isel ? DW'(w_imm) : r_regs[w_imm[2:0]];
  assign w_shamt   = w_src2 % LP_DW;
  assign w_pcPlus1 = r_pc + PCW'(1);
  assign w_sum     = {1'b0, w_src1} + {1'b0, w_src2};
  assign w_diff    = {1'b0, w_src1} - {1'b0, w_src2};

  assign imem_req   = (r_state == S_FETCH) && !rst;
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = r_dmemWe;
  assign dmem_addr  = r_dmemAddr;
  assign dmem_wdata = r_dmemWdata;
  assign out_port   = r_outPort;
  assign halted     = (r_state == S_HALT);

  always_comb begin
    w_aluRes = '0;
    w_aluV   = 1'b0;
    w_aluC   = 1'b0;
    case (w_op[3:0])
      4'd0: begin
        w_aluRes = w_sum[DW-1:0];
        w_aluC   = w_sum[DW];
        w_aluV   = (w_src1[DW-1] == w_src2[DW-1]) && (w_aluRes[DW-1] != w_src1[DW-1]);
      end
      4'd1, 4'd8: begin
        w_aluRes = w_diff[DW-1:0];
        w_aluC   = w_diff[DW];
        w_aluV   = (w_src1[DW-1] != w_src2[DW-1]) && (w_aluRes[DW-1] != w_src1[DW-1]);
      end
      4'd2: w_aluRes = w_src1 & w_src2;
      4'd3: w_aluRes = w_src1 | w_src2;
      4'd4: w_aluRes = w_src1 ^ w_src2;
      4'd5: w_aluRes = w_src1 << w_shamt;
      4'd6: w_aluRes = w_src1 >> w_shamt;
      4'd7: w_aluRes = w_src2;
      default: w_aluRes = '0;
    endcase
  end

  // Flags are held as {N,Z,V,C}; branch condition index comes from the rs1 field.
  always_comb begin
    w_cond = 1'b0;
    case (w_rs1)
      3'd0: w_cond = r_flags[2];
      3'd1: w_cond = r_flags[1];
      3'd2: w_cond = ~r_flags[2] & ~(r_flags[3] ^ r_flags[1]);
      3'd3: w_cond = ~(r_flags[3] ^ r_flags[1]);
      3'd4: w_cond = ~(r_flags[0] | r_flags[2]);
      3'd5: w_cond = ~r_flags[0];
      3'd6: w_cond = r_flags[3];
      default: w_cond = 1'b1;
    endcase
    w_taken = w_cond ^ w_op[0];
  end

  always_comb begin
    w_inVal = '0;
    for (int k = 0; k < NIN; k++) begin
      if (w_src2 == DW'(k)) w_inVal = in_port[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_regWe     = 1'b0;
    w_regWdata  = '0;
    w_flagWe    = 1'b0;
    w_pcWe      = 1'b0;
    w_pcNext    = w_pcPlus1;
    w_outWe     = 1'b0;
    w_memStart  = 1'b0;
    case (r_state)
      S_FETCH: if (imem_ack) w_nextState = S_EXEC;
      S_EXEC: begin
        w_nextState = S_FETCH;
        w_pcWe      = 1'b1;
        if (!w_op[4]) begin
          if (w_op[3:0] <= 4'd8) begin
            w_flagWe   = 1'b1;
            w_regWe    = (w_op[3:0] != 4'd8);
            w_regWdata = w_aluRes;
          end
        end else begin
          case (w_op)
            5'b10000, 5'b10001: if (w_taken) w_pcNext = w_src2[PCW-1:0];
            5'b10010: begin
              w_regWe    = 1'b1;
              w_regWdata = DW'(w_pcPlus1);
              w_pcNext   = w_src2[PCW-1:0];
            end
            5'b10100, 5'b10101: begin
              w_pcWe      = 1'b0;
              w_memStart  = 1'b1;
              w_nextState = S_MEM;
            end
            5'b10110: begin
              w_regWe    = 1'b1;
              w_regWdata = w_inVal;
            end
            5'b10111: w_outWe = 1'b1;
            5'b11111: begin
              w_pcWe      = 1'b0;
              w_nextState = S_HALT;
            end
            default: w_pcWe = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          w_nextState = S_FETCH;
          w_pcWe      = 1'b1;
          w_regWe     = !r_dmemWe;
          w_regWdata  = dmem_rdata;
        end
      end
      S_HALT:  w_nextState = S_HALT;
      default: w_nextState = S_FETCH;
    endcase
  end

  // Datapath state; dmem outputs are registered so they stay frozen for the whole MEM wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir        <= '0;
      r_pc        <= '0;
      r_flags     <= '0;
      r_outPort   <= '0;
      r_dmemWe    <= 1'b0;
      r_dmemAddr  <= '0;
      r_dmemWdata <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ack) r_ir <= imem_rdata;
      if (w_regWe) r_regs[w_rd] <= w_regWdata;
      if (w_flagWe) r_flags <= {w_aluRes[DW-1], (w_aluRes == '0), w_aluV, w_aluC};
      if (w_pcWe) r_pc <= w_pcNext;
      for (int k = 0; k < NOUT; k++) begin
        if (w_outWe && w_src2 == DW'(k)) r_outPort[k*DW +: DW] <= w_src1;
      end
      if (w_memStart) begin
        r_dmemWe    <= w_op[0];
        r_dmemAddr  <= w_src2;
        r_dmemWdata <= w_src1;
      end else if (r_state == S_MEM && dmem_ack) begin
        r_dmemWe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sips_core.sv
// tb_sips_core: directed programs with hand-computed results, run on a DW=8/PCW=8
// core plus a PCW=4 core for program counter wrap and JAL checks.
module tb_sips_core;

  localparam int DW   = 8;
  localparam int PCW  = 8;
  localparam int NIN  = 2;
  localparam int NOUT = 2;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SHL  = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_MOV  = 5'b00111;
  localparam logic [4:0] OP_CMP  = 5'b01000;
  localparam logic [4:0] OP_NOP  = 5'b01001;
  localparam logic [4:0] OP_BR   = 5'b10000;
  localparam logic [4:0] OP_BRN  = 5'b10001;
  localparam logic [4:0] OP_JAL  = 5'b10010;
  localparam logic [4:0] OP_LD   = 5'b10100;
  localparam logic [4:0] OP_ST   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [15:0] HALT_WORD = 16'hF800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               imemReq;
  logic [PCW-1:0]     imemAddr;
  logic               imemAck;
  logic [15:0]        imemRdata;
  logic               dmemReq;
  logic               dmemWe;
  logic [DW-1:0]      dmemAddr;
  logic [DW-1:0]      dmemWdata;
  logic               dmemAck;
  logic [DW-1:0]      dmemRdata;
  logic [NIN*DW-1:0]  inPort;
  logic [NOUT*DW-1:0] outPort;
  logic               haltedOut;

  logic [15:0] imem [256];
  logic [7:0]  dmemArr [256];
  logic        imemStall;
  logic        strayAck;
  int          dmemDelay;
  int          dmemCnt = 0;

  assign imemAck   = imemReq && !imemStall;
  assign imemRdata = imem[imemAddr];
  assign dmemAck   = (dmemReq && (dmemCnt == dmemDelay)) || strayAck;
  assign dmemRdata = dmemArr[dmemAddr];

  always @(posedge clk) begin
    if (!dmemReq || dmemAck) dmemCnt <= 0;
    else                     dmemCnt <= dmemCnt + 1;
    if (dmemReq && dmemAck && dmemWe) dmemArr[dmemAddr] <= dmemWdata;
  end

  sips_core #(.DW(DW), .PCW(PCW), .NIN(NIN), .NOUT(NOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
    .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata),
    .dmem_ack(dmemAck), .dmem_rdata(dmemRdata),
    .in_port(inPort), .out_port(outPort), .halted(haltedOut)
  );

  // Second core with a 4-bit program counter, no data memory traffic.
  logic               rst4;
  logic               imemReq4;
  logic [3:0]         imemAddr4;
  logic [15:0]        imem4 [16];
  logic               dmemReq4;
  logic               dmemWe4;
  logic [DW-1:0]      dmemAddr4;
  logic [DW-1:0]      dmemWdata4;
  logic [NOUT*DW-1:0] outPort4;
  logic               halted4;
  logic [15:0]        imemRdata4;

  assign imemRdata4 = imem4[imemAddr4];

  sips_core #(.DW(DW), .PCW(4), .NIN(NIN), .NOUT(NOUT)) dut4 (
    .clk(clk), .rst(rst4),
    .imem_req(imemReq4), .imem_addr(imemAddr4), .imem_ack(imemReq4), .imem_rdata(imemRdata4),
    .dmem_req(dmemReq4), .dmem_we(dmemWe4), .dmem_addr(dmemAddr4), .dmem_wdata(dmemWdata4),
    .dmem_ack(1'b0), .dmem_rdata(8'h00),
    .in_port(16'h0000), .out_port(outPort4), .halted(halted4)
  );

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rs1,
                                      input logic [3:0] f, input logic [2:0] rd, input logic isel);
    return {op, rs1, f, rd, isel};
  endfunction

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic holdReset();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = HALT_WORD;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    rst4      = 1'b0;
    imemStall = 1'b0;
    strayAck  = 1'b0;
    dmemDelay = 0;
    inPort    = {8'h5C, 8'h3B};
    for (int i = 0; i < 256; i++) dmemArr[i] = 8'h00;
    for (int i = 0; i < 16; i++) imem4[i] = HALT_WORD;
    #2;
    rst4 = 1'b1;
    holdReset();
    #1;
    checkOutput("rstImemReq", imemReq, 0);
    checkOutput("rstDmemReq", dmemReq, 0);
    checkOutput("rstDmemWe", dmemWe, 0);
    checkOutput("rstHalted", haltedOut, 0);
    checkOutput("rstOutPort", outPort, 0);
    checkOutput("rstImemAddr", imemAddr, 0);

    $display("[TB] MOV/ADD/OUT/HALT program");
    imem[0] = enc(OP_MOV, 3'd0, 4'd9, 3'd1, 1'b1);
    imem[1] = enc(OP_ADD, 3'd1, 4'd9, 3'd2, 1'b1);
    imem[2] = enc(OP_OUT, 3'd2, 4'd0, 3'd0, 1'b1);
    releaseReset();
    #1;
    checkOutput("firstImemReq", imemReq, 1);
    applyStimulus(7);
    checkOutput("haltedAt7", haltedOut, 0);
    applyStimulus(1);
    checkOutput("haltedAt8", haltedOut, 1);
    checkOutput("outAt8", outPort, 16'h0012);
    applyStimulus(3);
    checkOutput("haltNoFetch", imemReq, 0);
    checkOutput("haltStays", haltedOut, 1);

    $display("[TB] overflow flags and branches");
    holdReset();
    imem[0]  = enc(OP_MOV, 3'd0, 4'd15, 3'd1, 1'b1);
    imem[1]  = enc(OP_SHL, 3'd1, 4'd3, 3'd1, 1'b1);
    imem[2]  = enc(OP_OR,  3'd1, 4'd7, 3'd1, 1'b1);
    imem[3]  = enc(OP_ADD, 3'd1, 4'd1, 3'd2, 1'b1);
    imem[4]  = enc(OP_BRN, 3'd2, 4'd15, 3'd0, 1'b1);
    imem[5]  = enc(OP_BR,  3'd1, 4'd8, 3'd0, 1'b1);
    imem[8]  = enc(OP_BR,  3'd5, 4'd10, 3'd0, 1'b1);
    imem[10] = enc(OP_BR,  3'd6, 4'd12, 3'd0, 1'b1);
    imem[12] = enc(OP_BR,  3'd0, 4'd14, 3'd0, 1'b1);
    imem[13] = enc(OP_OUT, 3'd2, 4'd1, 3'd0, 1'b1);
    releaseReset();
    applyStimulus(10);
    checkOutput("brnCond2NotTaken", imemAddr, 5);
    applyStimulus(2);
    checkOutput("brVTaken", imemAddr, 8);
    applyStimulus(2);
    checkOutput("brNotCTaken", imemAddr, 10);
    applyStimulus(2);
    checkOutput("brNTaken", imemAddr, 12);
    applyStimulus(2);
    checkOutput("brZNotTaken", imemAddr, 13);
    applyStimulus(2);
    checkOutput("addOverflowOut", outPort, 16'h8000);
    applyStimulus(2);
    checkOutput("flagsProgHalted", haltedOut, 1);

    $display("[TB] SUB/XOR/SHR/AND/CMP with register operands");
    holdReset();
    imem[0]  = enc(OP_MOV, 3'd0, 4'd3, 3'd1, 1'b1);
    imem[1]  = enc(OP_MOV, 3'd0, 4'd5, 3'd2, 1'b1);
    imem[2]  = enc(OP_SUB, 3'd1, 4'd2, 3'd3, 1'b0);
    imem[3]  = enc(OP_BR,  3'd4, 4'd9, 3'd0, 1'b1);
    imem[4]  = enc(OP_XOR, 3'd3, 4'd15, 3'd4, 1'b1);
    imem[5]  = enc(OP_SHR, 3'd4, 4'd4, 3'd4, 1'b1);
    imem[6]  = enc(OP_AND, 3'd4, 4'd2, 3'd5, 1'b0);
    imem[7]  = enc(OP_CMP, 3'd5, 4'd5, 3'd5, 1'b1);
    imem[8]  = enc(OP_BR,  3'd0, 4'd11, 3'd0, 1'b1);
    imem[11] = enc(OP_OUT, 3'd5, 4'd0, 3'd0, 1'b1);
    imem[12] = enc(OP_OUT, 3'd3, 4'd1, 3'd0, 1'b1);
    releaseReset();
    applyStimulus(8);
    checkOutput("borrowBlocksHi", imemAddr, 4);
    applyStimulus(10);
    checkOutput("cmpZeroTaken", imemAddr, 11);
    applyStimulus(2);
    checkOutput("cmpNoWriteback", outPort, 16'h0005);
    applyStimulus(2);
    checkOutput("subResultOut", outPort, 16'hFE05);
    applyStimulus(2);
    checkOutput("aluProgHalted", haltedOut, 1);

    $display("[TB] store/load with delayed data ack");
    holdReset();
    dmemDelay = 4;
    imem[0] = enc(OP_MOV, 3'd0, 4'd10, 3'd1, 1'b1);
    imem[1] = enc(OP_SHL, 3'd1, 4'd4, 3'd1, 1'b1);
    imem[2] = enc(OP_OR,  3'd1, 4'd5, 3'd1, 1'b1);
    imem[3] = enc(OP_ST,  3'd1, 4'd3, 3'd0, 1'b1);
    imem[4] = enc(OP_LD,  3'd0, 4'd3, 3'd3, 1'b1);
    imem[5] = enc(OP_OUT, 3'd3, 4'd0, 3'd0, 1'b1);
    releaseReset();
    applyStimulus(8);
    checkOutput("stIssue", {dmemReq, dmemWe, dmemAddr, dmemWdata}, 32'h303A5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("stHold%0d", i), {dmemReq, dmemWe, dmemAddr, dmemWdata}, 32'h303A5);
    end
    applyStimulus(1);
    checkOutput("stDone", dmemReq, 0);
    checkOutput("stWritten", dmemArr[3], 8'hA5);
    applyStimulus(2);
    checkOutput("ldIssue", {dmemReq, dmemWe, dmemAddr}, 32'h203);
    applyStimulus(5);
    checkOutput("ldDone", dmemReq, 0);
    applyStimulus(2);
    checkOutput("ldValueOut", outPort, 16'h00A5);
    applyStimulus(2);
    checkOutput("memProgHalted", haltedOut, 1);

    $display("[TB] IN/OUT port index bounds");
    holdReset();
    dmemDelay = 0;
    imem[0] = enc(OP_MOV, 3'd0, 4'd15, 3'd4, 1'b1);
    imem[1] = enc(OP_IN,  3'd0, 4'd1, 3'd5, 1'b1);
    imem[2] = enc(OP_OUT, 3'd5, 4'd0, 3'd0, 1'b1);
    imem[3] = enc(OP_OUT, 3'd4, 4'd1, 3'd0, 1'b1);
    imem[4] = enc(OP_IN,  3'd0, 4'd2, 3'd4, 1'b1);
    imem[5] = enc(OP_OUT, 3'd5, 4'd2, 3'd0, 1'b1);
    imem[6] = enc(OP_OUT, 3'd4, 4'd0, 3'd0, 1'b1);
    releaseReset();
    applyStimulus(8);
    checkOutput("ioInAndOut", outPort, 16'h0F5C);
    applyStimulus(4);
    checkOutput("outIndexIgnored", outPort, 16'h0F5C);
    applyStimulus(2);
    checkOutput("inIndexZero", outPort, 16'h0F00);
    applyStimulus(2);
    checkOutput("ioProgHalted", haltedOut, 1);

    $display("[TB] reset during data wait with stray ack");
    holdReset();
    dmemDelay = 10;
    imem[0] = enc(OP_MOV, 3'd0, 4'd7, 3'd1, 1'b1);
    imem[1] = enc(OP_OUT, 3'd1, 4'd1, 3'd0, 1'b1);
    imem[2] = enc(OP_ST,  3'd1, 4'd2, 3'd0, 1'b1);
    releaseReset();
    applyStimulus(7);
    checkOutput("midMemReq", dmemReq, 1);
    checkOutput("midMemOut", outPort, 16'h0700);
    #2;
    holdReset();
    imemStall = 1'b1;
    #1;
    checkOutput("asyncDmemReq", dmemReq, 0);
    checkOutput("asyncImemReq", imemReq, 0);
    checkOutput("asyncPc", imemAddr, 0);
    checkOutput("asyncOut", outPort, 0);
    checkOutput("asyncDmemWe", dmemWe, 0);
    imem[0] = enc(OP_ADD, 3'd1, 4'd3, 3'd2, 1'b1);
    imem[1] = enc(OP_OUT, 3'd2, 4'd0, 3'd0, 1'b1);
    releaseReset();
    strayAck = 1'b1;
    applyStimulus(3);
    strayAck = 1'b0;
    checkOutput("strayFetchReq", imemReq, 1);
    checkOutput("strayPc", imemAddr, 0);
    checkOutput("strayDmemReq", dmemReq, 0);
    checkOutput("strayNoStore", dmemArr[2], 8'h00);
    imemStall = 1'b0;
    applyStimulus(4);
    checkOutput("regsCleared", outPort, 16'h0003);
    applyStimulus(2);
    checkOutput("rstProgHalted", haltedOut, 1);

    $display("[TB] PCW=4 wrap and JAL");
    for (int i = 0; i < 5; i++) imem4[i] = enc(OP_NOP, 3'd0, 4'd0, 3'd0, 1'b0);
    imem4[5]  = enc(OP_JAL, 3'd0, 4'd14, 3'd3, 1'b1);
    imem4[14] = enc(OP_OUT, 3'd3, 4'd0, 3'd0, 1'b1);
    imem4[15] = enc(OP_NOP, 3'd0, 4'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst4 = 1'b0;
    applyStimulus(12);
    checkOutput("jalTarget", imemAddr4, 14);
    applyStimulus(2);
    checkOutput("jalLink", outPort4, 16'h0006);
    checkOutput("pcAt15", imemAddr4, 15);
    applyStimulus(2);
    checkOutput("pcWrap", imemAddr4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sips_core.md
SIPS_CORE -- requirements
Module: sips_core

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the data and register width in bits (4..16).
REQ-002 SHALL have parameter PCW, default 8, meaning the program counter width, constrained PCW <= DW.
REQ-003 SHALL have parameter NIN, default 2, meaning the number of DW-bit input ports (1..16).
REQ-004 SHALL have parameter NOUT, default 2, meaning the number of DW-bit output ports (1..16).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  PCW  fetch address, equal to PC.
REQ-009 imem_ack  in  1  fetch complete; imem_rdata is valid in that cycle.
REQ-010 imem_rdata  in  16  instruction word.
REQ-011 dmem_req  out  1  data memory request.
REQ-012 dmem_we  out  1  1 = store, 0 = load.
REQ-013 dmem_addr  out  DW  data address.
REQ-014 dmem_wdata  out  DW  store data.
REQ-015 dmem_ack  in  1  data access complete; dmem_rdata is valid in that cycle for loads.
REQ-016 dmem_rdata  in  DW  load data.
REQ-017 in_port  in  NIN*DW  input ports, port k at bits [k*DW +: DW].
REQ-018 out_port  out  NOUT*DW  registered output ports, same packing as in_port.
REQ-019 halted  out  1  core has executed HALT.

Function
REQ-020 Instruction encoding SHALL be as follows:
- op = [15:11]
- rs1 = [10:8]
- rs2/imm4 = [7:4]
- rd = [3:1]
- isel = [0]
REQ-021 src1 SHALL be R[rs1]; src2 SHALL be zero-extended imm4 when isel=1, otherwise R[rs2[2:0]].
REQ-022 The register file SHALL contain 8 registers of DW bits each, and all 8 SHALL be writable.
REQ-023 The core SHALL be implemented as an FSM with states FETCH, EXEC, MEM, HALT.
REQ-024 FETCH behaviour:
- imem_req SHALL be 1 and imem_addr SHALL be PC, held stable until imem_ack.
- On imem_ack, the core SHALL latch the instruction and move to EXEC.
REQ-025 EXEC SHALL last exactly one cycle and perform writeback, flag update and PC update, then return to FETCH, except where REQ-030 and REQ-032 apply.
REQ-026 ALU ops (op[4]=0) SHALL compute rd <= f(src1, src2) modulo 2^DW, with op[3:0] selecting:
- 0 ADD, 1 SUB (src1-src2), 2 AND, 3 OR, 4 XOR
- 5 SHL by src2 mod DW, 6 SHR logical, 7 MOV (src2)
- 8 CMP (SUB without writeback)
- 9..15 NOP
REQ-027 Flags {N,Z,V,C} SHALL update only on ALU ops 0..8:
- N = result MSB; Z = result==0.
- C = carry out for ADD and borrow for SUB/CMP, else 0.
- V = signed overflow for ADD/SUB/CMP, else 0.
REQ-028 Branch op 1000x, with condition index cond = rs1 field:
- Condition SHALL be: 0 Z, 1 V, 2 ~Z&~(N^V), 3 ~(N^V), 4 ~(C|Z), 5 ~C, 6 N, 7 always.
- Taken = cond XOR op[0].
- When taken, PC <= src2[PCW-1:0]; otherwise PC <= PC+1.
REQ-029 JAL (10010) SHALL write rd <= zero-extended PC+1 and set PC <= src2[PCW-1:0].
REQ-030 LD (10100) and ST (10101) in EXEC SHALL move to MEM:
- dmem_addr = src2, dmem_we = (ST), dmem_wdata = R[rs1].
- dmem_req and all dmem outputs SHALL be held until dmem_ack.
- On ack, LD SHALL write rd <= dmem_rdata, then PC <= PC+1 and the FSM SHALL go to FETCH.
REQ-031 IN (10110) and OUT (10111):
- IN SHALL write rd <= in_port[src2]; an index >= NIN SHALL write 0.
- OUT SHALL set out_port[src2] <= R[rs1]; an index >= NOUT SHALL be ignored.
REQ-032 HALT (11111) SHALL enter HALT and set halted=1; the core SHALL stay in HALT until rst, issuing no requests.
REQ-033 All other opcodes SHALL be NOPs, with PC <= PC+1.
REQ-034 PC arithmetic SHALL wrap modulo 2^PCW.
REQ-035 Ack behaviour:
- An ack received while the corresponding req=0 SHALL be ignored.
- Ack may arrive in the same cycle req is first raised, giving a minimum FETCH length of 1 cycle.
REQ-036 Minimum latency per instruction SHALL be 2 cycles, and 3 cycles for LD/ST.

Reset
REQ-037 On rst=1, immediately and independent of clk, the core SHALL set:
- state = FETCH and PC = 0
- all registers, flags and out_port = 0
- halted = 0, imem_req = 0, dmem_req = 0, dmem_we = 0
REQ-038 imem_req SHALL assert in the first cycle after rst deasserts.
REQ-039 Reset asserted during FETCH or MEM SHALL abandon the transaction; any late ack SHALL be ignored per REQ-035.

Verification
REQ-040 DW=8, zero-wait acks, program MOV r1,#9; ADD r2,r1,#9; OUT r2->port 0; HALT -> out_port[7:0]=0x12, halted=1 after 8 cycles.
REQ-041 ADD of 0x7F+#1 then branch cond 2 -> flags N=1, V=1, C=0, Z=0; branch not taken, PC increments by 1.
REQ-042 Store 0xA5 to address 3 with dmem_ack delayed 4 cycles, then LD from 3 -> dmem outputs stable throughout the wait; rd=0xA5.
REQ-043 PCW=4, execute at PC=15 a NOP -> next imem_addr=0; JAL at PC=5 -> rd=6.
REQ-044 IN from index NIN and OUT to index NOUT -> rd=0 and out_port unchanged.
REQ-045 rst pulsed mid-MEM wait followed by a stray dmem_ack -> state FETCH, PC=0, registers 0, stray ack has no effect.
